// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
// The parity state is only reachable when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready push interface into the UART transmit FIFO.
interface uart_tx_fifo_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered head data; the head becomes poppable one
// cycle after it is written, and the popped entry is not counted.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic             avail_q;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && avail_q;
  assign rdata   = rdata_q;
  assign empty   = !avail_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      avail_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      // Head flag lags the count so rdata_q always holds the entry it advertises.
      avail_q <= (count != '0) && !do_pop;
      rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO, LSB first, programmable bit period.
// Define UART_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            clkdiv,
  uart_tx_fifo_if.slave               in_if,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] head;

  state_e           state_q;
  logic [DIV_W-1:0] div_q, bit_cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       idx_q;
  logic             tx_q, busy_q;
  logic             bit_wrap, stop_last;
`ifdef UART_PARITY_EN
  logic             par_q;
`endif

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (in_if.in_valid),
    .wdata  (in_if.in_data),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign in_if.in_ready = !fifo_full;
  assign tx             = tx_q;
  assign busy           = busy_q;

  assign bit_wrap  = (bit_cnt_q == div_q);
  assign stop_last = (idx_q == 3'(STOP_BITS - 1));

  // A frame starts from idle, or straight out of the last stop bit with no gap.
  always_comb begin
    pop = 1'b0;
    if (enable && !fifo_empty) begin
      pop = (state_q == StIdle) || ((state_q == StStop) && bit_wrap && stop_last);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else if (pop) begin
      state_q   <= StStart;
      div_q     <= clkdiv;
      bit_cnt_q <= '0;
      shift_q   <= head;
      idx_q     <= '0;
      tx_q      <= 1'b0;
      busy_q    <= 1'b1;
`ifdef UART_PARITY_EN
      par_q     <= even_parity(head);
`endif
    end else if (state_q != StIdle) begin
      if (!bit_wrap) begin
        bit_cnt_q <= bit_cnt_q + DIV_W'(1);
      end else begin
        bit_cnt_q <= '0;
        case (state_q)
          StStart: begin
            state_q <= StData;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
          StData: begin
            if (idx_q == 3'(DATA_BITS - 1)) begin
              idx_q <= '0;
`ifdef UART_PARITY_EN
              state_q <= StParity;
              tx_q    <= par_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
`ifdef UART_PARITY_EN
          StParity: begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
`endif
          StStop: begin
            if (stop_last) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, with a serial
// line receiver that rebuilds each frame from first principles.
module tb_uart_tx_fifo;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] clkdiv = '0;
  logic        tx, busy;
  logic [3:0]  fifo_count;

  uart_tx_fifo_if in_if ();

  uart_tx_fifo #(
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .enable     (enable),
    .clkdiv     (clkdiv),
    .in_if      (in_if),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] div_seen = '0;
  logic [7:0]  exp_q[$];
  int          start_t[$];
  int          started = 0;
  int          done = 0;
  int          pushed = 0;
  bit          mon_en = 1'b1;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    div_seen <= clkdiv;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver: called on the first low sample of a start bit; bit period is the
  // divisor that was on clkdiv at the edge where the line fell.
  task automatic do_frame();
    int                    p;
    int                    bad_shape;
    logic [7:0]            b;
    logic [7:0]            rx;
    logic                  obs;
    logic [FRAME_BITS-1:0] bits;
    p = int'(div_seen) + 1;
    start_t.push_back(cyc);
    started++;
    check("busy_at_start", busy, 1);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 1, 0);
      b = '0;
    end else begin
      b = exp_q.pop_front();
    end
`ifdef UART_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    bad_shape = 0;
    rx = '0;
    obs = 1'b0;
    for (int k = 0; k < FRAME_BITS; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k != 0 || j != 0) @(negedge clock);
        if (j == 0) obs = tx;
        else if (tx !== obs) bad_shape++;
      end
      if (k >= 1 && k <= 8) rx[k-1] = obs;
      else check($sformatf("frame%0d_bit%0d", started, k), obs, bits[k]);
    end
    check($sformatf("frame%0d_shape", started), bad_shape, 0);
    check($sformatf("frame%0d_byte", started), rx, b);
    done++;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && resetb && tx === 1'b0) do_frame();
    end
  end

  // Call at a negedge; the byte is offered across exactly one rising edge.
  task automatic push(input logic [7:0] b, input bit acc);
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    @(posedge clock);
    if (acc && mon_en) begin
      exp_q.push_back(b);
      pushed++;
    end
    @(negedge clock);
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (done < target) check({"timeout_", tag}, done, target);
    @(negedge clock);
  endtask

  initial begin
    int s, t, lows;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    enable = 1'b1;
    clkdiv = 16'd3;
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_if.in_ready, 1);
    resetb = 1'b1;
    @(negedge clock);

    // Single byte, start bit on the 2nd edge after the push edge.
    push(8'h55, 1'b1);
    check("lat_edge0", tx, 1);
    @(negedge clock);
    check("lat_edge1", tx, 1);
    @(negedge clock);
    check("lat_edge2", tx, 0);
    wait_done(1, 100, "single");
    check("single_busy_after", busy, 0);
    check("single_tx_after", tx, 1);

    // Back-to-back frames at one cycle per bit.
    clkdiv = 16'd0;
    s = start_t.size();
    t = done + 3;
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    push(8'hFF, 1'b1);
    wait_done(t, 200, "b2b");
    if (start_t.size() >= s + 3) begin
      check("b2b_gap1", start_t[s+1] - start_t[s], FRAME_BITS);
      check("b2b_gap2", start_t[s+2] - start_t[s+1], FRAME_BITS);
    end

    // Parity-sensitive bytes.
    clkdiv = 16'd2;
    t = done + 2;
    push(8'h07, 1'b1);
    push(8'h03, 1'b1);
    wait_done(t, 200, "parity");

    // Fill the FIFO while disabled; the 9th byte must bounce.
    enable = 1'b0;
    clkdiv = 16'd1;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("fill_ready%0d", k), in_if.in_ready, (k < 8));
      push(8'($urandom), (k < 8));
    end
    check("full_count", fifo_count, 8);
    check("full_ready", in_if.in_ready, 0);
    check("full_idle", busy, 0);
    enable = 1'b1;
    t = done + 8;
    wait_done(t, 400, "full_drain");
    check("drain_count", fifo_count, 0);
    check("drain_busy", busy, 0);

    // Drop enable and change clkdiv mid-frame.
    clkdiv = 16'd7;
    s = started;
    t = done + 1;
    push(8'h81, 1'b1);
    push(8'h42, 1'b1);
    for (int n = 0; n < 20 && started == s; n++) @(negedge clock);
    check("mid_started", started, s + 1);
    repeat (30) @(negedge clock);
    enable = 1'b0;
    clkdiv = 16'd1;
    wait_done(t, 200, "mid_frame");
    repeat (40) @(negedge clock);
    check("mid_no_restart", started, s + 1);
    check("mid_busy", busy, 0);
    check("mid_count", fifo_count, 1);
    enable = 1'b1;
    wait_done(t + 1, 100, "mid_resume");

    // Asynchronous reset in the middle of a frame.
    mon_en = 1'b0;
    clkdiv = 16'd3;
    push(8'h99, 1'b0);
    push(8'h66, 1'b0);
    repeat (12) @(negedge clock);
    check("pre_rst_busy", busy, 1);
    #2 resetb = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ready", in_if.in_ready, 1);
    @(negedge clock);
    resetb = 1'b1;
    mon_en = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_idle", lows, 0);
    check("post_rst_busy", busy, 0);

    // Random traffic; never more than 7 bytes outstanding, so every push lands.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) clkdiv = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0 && (pushed - started) < 7) begin
        check("rand_ready", in_if.in_ready, 1);
        push(8'($urandom), 1'b1);
      end else begin
        @(negedge clock);
      end
    end
    enable = 1'b1;
    wait_done(pushed, 3000, "rand_drain");
    check("final_count", fifo_count, 0);
    check("final_busy", busy, 0);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable UART transmitter for the user project area. It drives a serial line into an mprj_io pad, which is the line our testbench UART receiver samples. Bytes arrive through a valid/ready byte interface into a small FIFO. They are serialized 8N1, LSB first, at a runtime-programmable bit period.

Parameters:
FIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2
DIV_W, 16, width of the baud divisor input

Ports:
clock  input  1  single system clock; all logic on rising edge
resetb  input  1  asynchronous active-low reset
enable  input  1  1 = frames may start; 0 = finish current frame, then hold idle
clkdiv  input  DIV_W  bit period minus one, in clock cycles
in_data  input  8  byte to transmit
in_valid  input  1  in_data is valid
in_ready  output  1  FIFO can accept a byte; equals !full
tx  output  1  serial line; idles high
busy  output  1  a frame is in progress (start through stop bit)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being shifted

Behaviour:
- Reset (resetb low, asynchronous): tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; tx returns high.
- Push: a byte is written on a rising edge where in_valid && in_ready. If the FIFO is full, in_ready=0 and the byte is not taken, even if a pop happens the same cycle. Push and pop in the same cycle when not full: fifo_count is unchanged.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE -> START: when enable=1 and the FIFO is not empty. On that edge the FSM pops the head byte into the shift register, latches clkdiv into div_q, sets busy=1, and drives tx=0.
- Bit timing: each bit lasts div_q+1 cycles. A bit counter counts 0..div_q and advances the state on wrap. clkdiv=0 gives 1 cycle per bit. Changing clkdiv mid-frame has no effect until the next frame.
- Latency: a byte pushed into an empty FIFO while IDLE and enabled appears as tx=0 on the 2nd rising edge after the push edge. The FIFO is registered, so the head is visible one cycle later.
- DATA: 8 bits, LSB first, shifting right. A 3-bit index counts 0..7.
- STOP: tx=1 for one bit period. Then:
  - if enable=1 and the FIFO is not empty, go directly to START with no extra idle cycle, and pop as above;
  - otherwise go to IDLE with busy=0.
- enable deasserted mid-frame: the current frame completes normally; no new frame starts.
- FIFO pointers wrap modulo FIFO_DEPTH. A full/empty extra bit distinguishes the two cases. Overflow is impossible by construction.
- tx is registered, with no combinational path from any input.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. For one bit period it drives the even parity bit (XOR of the 8 data bits). A frame is 11 bits.
- Undefined: there is no PARITY state and the frame is 10 bits. The state encoding may omit the parity code.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constants DATA_BITS=8, STOP_BITS=1
  - function even_parity(byte)
- Sub-module uart_sync_fifo (parameters DEPTH, WIDTH=8): push/pop/full/empty/count, with registered read data. The top level holds only the FSM, the bit counter and the shift register.

Test Plan:
- Reset: assert resetb=0 mid-frame with clkdiv=3 -> tx=1, busy=0, fifo_count=0 asynchronously; after release, no residual frame.
- Single byte: clkdiv=3, push 0x55 -> tx=0 two edges after the push, then 1,0,1,0,1,0,1,0 LSB first, then stop=1. Each bit is 4 cycles, 40 cycles total; busy=0 afterwards.
- Back-to-back: clkdiv=0, push 0xA5, 0x3C, 0xFF consecutively -> three contiguous 10-cycle frames with no idle gap between stop and start. The scoreboard decodes A5, 3C, FF.
- Full FIFO: enable=0, push 9 bytes with FIFO_DEPTH=8 -> in_ready=0 after the 8th byte, 9th not accepted, fifo_count=8. Set enable=1 -> 8 frames in order, then fifo_count=0.
- Enable/clkdiv change mid-frame: during the DATA bits of 0x81 (clkdiv=7), drop enable and set clkdiv=1 -> the frame finishes at 8 cycles/bit and no next frame starts. Re-enable -> the next frame uses 2 cycles/bit.
- UART_PARITY_EN: send 0x07 -> parity bit 1, 11-bit frame. Send 0x03 -> parity bit 0.
